// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI command RAM: command encodings, FSM state
// type and small elaboration-time helpers.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // IDLE: no read data outstanding. TX_HOLD: dout/tx_valid held until tx_ack.
  typedef enum logic {
    IDLE    = 1'b0,
    TX_HOLD = 1'b1
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // True when an address selects an implemented word.
  function automatic logic in_range(input int addr, input int depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/spi_ram_array.sv
// Single-port storage: synchronous write, registered read. Out-of-range
// writes are dropped and out-of-range reads return zero. The read register
// clears on reset; the memory words themselves are never cleared.
module spi_ram_array
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic w_ok;
  logic r_ok;

  assign w_ok = in_range(int'(waddr), MEM_DEPTH);
  assign r_ok = in_range(int'(raddr), MEM_DEPTH);

  // Word write; no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we && w_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: loads only on a read request, otherwise holds its value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= r_ok ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/spi_cmd_ram.sv
// Command-decoding RAM behind an SPI slave shift register.
// Frame = {cmd[1:0], payload}. Independent write/read address registers,
// read data returned through a tx_valid/tx_ack hold handshake.
// Optional build macro SPI_RAM_ADDR_AUTOINC_EN: accepted WR_DATA / RD_DATA
// post-increment their address register (MEM_DEPTH-1 wraps to 0).
//
// Handshake: a read accepted at edge N loads dout and raises tx_valid for
// cycle N+1. tx_valid and dout then hold until a cycle with tx_ack=1; that
// edge drops tx_valid unless the same edge also accepts a new RD_DATA, in
// which case dout reloads and tx_valid stays high. RD_DATA arriving while
// tx_valid=1 and tx_ack=0 is rejected with a one-cycle err pulse.
module spi_cmd_ram
  import spi_ram_pkg::*;
#(
  parameter  int ADDR_WIDTH = 8,
  parameter  int DATA_WIDTH = 8,
  parameter  int MEM_DEPTH  = 256,
  localparam int PAYLOAD_W  = max_int(ADDR_WIDTH, DATA_WIDTH),
  localparam int FRAME_W    = PAYLOAD_W + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_W-1:0]    din,
  input  logic                  rx_valid,
  input  logic                  tx_ack,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  err
);

  logic [1:0]            cmd;
  logic [PAYLOAD_W-1:0]  payload;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  state_e                state;

  logic is_wr_addr;
  logic is_wr_data;
  logic is_rd_addr;
  logic is_rd_data;
  logic wr_in_range;
  logic rd_in_range;
  logic rd_accept;
  logic rd_reject;
  logic wr_do;
  logic wr_bad;

  assign cmd     = din[FRAME_W-1 -: 2];
  assign payload = din[PAYLOAD_W-1:0];

  assign is_wr_addr = rx_valid && (cmd == CMD_WR_ADDR);
  assign is_wr_data = rx_valid && (cmd == CMD_WR_DATA);
  assign is_rd_addr = rx_valid && (cmd == CMD_RD_ADDR);
  assign is_rd_data = rx_valid && (cmd == CMD_RD_DATA);

  assign wr_in_range = in_range(int'(wr_addr), MEM_DEPTH);
  assign rd_in_range = in_range(int'(rd_addr), MEM_DEPTH);

  // A read is taken when nothing is outstanding or the outstanding word is
  // being acknowledged on this same edge.
  assign rd_accept = is_rd_data && ((state == IDLE) || tx_ack);
  assign rd_reject = is_rd_data && (state == TX_HOLD) && !tx_ack;
  assign wr_do     = is_wr_data && wr_in_range;
  assign wr_bad    = is_wr_data && !wr_in_range;

`ifdef SPI_RAM_ADDR_AUTOINC_EN
  function automatic logic [ADDR_WIDTH-1:0] bump(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) == MEM_DEPTH - 1) ? '0 : a + ADDR_WIDTH'(1);
  endfunction
`endif

  spi_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_do),
    .waddr(wr_addr),
    .wdata(payload[DATA_WIDTH-1:0]),
    .re   (rd_accept),
    .raddr(rd_addr),
    .rdata(dout)
  );

  // Address registers, error pulse and the IDLE/TX_HOLD handshake FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_valid <= 1'b0;
      err      <= 1'b0;
      state    <= IDLE;
    end else begin
      err <= rd_reject || wr_bad || (rd_accept && !rd_in_range);

      if (is_wr_addr) begin
        wr_addr <= payload[ADDR_WIDTH-1:0];
      end
`ifdef SPI_RAM_ADDR_AUTOINC_EN
      else if (is_wr_data) begin
        wr_addr <= bump(wr_addr);
      end
`endif

      if (is_rd_addr) begin
        rd_addr <= payload[ADDR_WIDTH-1:0];
      end
`ifdef SPI_RAM_ADDR_AUTOINC_EN
      else if (rd_accept) begin
        rd_addr <= bump(rd_addr);
      end
`endif

      case (state)
        IDLE: begin
          if (rd_accept) begin
            tx_valid <= 1'b1;
            state    <= TX_HOLD;
          end
        end
        TX_HOLD: begin
          if (rd_accept) begin
            tx_valid <= 1'b1;
          end else if (tx_ack) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ram.sv
// Testbench for spi_cmd_ram (MEM_DEPTH=200 so out-of-range addresses exist).
// Directed vector table, hand sequences, then random frames checked against
// a frame-level reference model.
module tb_spi_cmd_ram;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 200;
  localparam int FW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] din = '0;
  logic          rx_valid = 1'b0;
  logic          tx_ack = 1'b0;
  logic [DW-1:0] dout;
  logic          tx_valid;
  logic          err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_mem [0:255];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  logic [7:0] m_dout;
  bit         m_hold;
  bit         m_err;

  typedef struct {
    bit         v;
    logic [1:0] c;
    logic [7:0] p;
    bit         a;
    logic [7:0] exp_dout;
    bit         exp_tv;
    bit         exp_err;
  } vec_t;

  vec_t tbl[$];

  spi_cmd_ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .rx_valid(rx_valid),
    .tx_ack  (tx_ack),
    .dout    (dout),
    .tx_valid(tx_valid),
    .err     (err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit v, logic [1:0] c, logic [7:0] p, bit a,
                              logic [7:0] d, bit tv, bit e);
    vec_t r;
    r.v = v; r.c = c; r.p = p; r.a = a;
    r.exp_dout = d; r.exp_tv = tv; r.exp_err = e;
    return r;
  endfunction

  function automatic logic [7:0] nxt(input logic [7:0] a);
    return (int'(a) == DEPTH - 1) ? 8'd0 : a + 8'd1;
  endfunction

  // Frame-level rules: what one clock edge does to the model.
  task automatic model_step(input bit v, input logic [1:0] c, input logic [7:0] p, input bit a);
    bit was_hold;
    bit acc;
    was_hold = m_hold;
    acc      = 1'b0;
    m_err    = 1'b0;
    if (v) begin
      case (c)
        2'b00: m_wr = p;
        2'b01: begin
          if (int'(m_wr) < DEPTH) m_mem[m_wr] = p;
          else m_err = 1'b1;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
          m_wr = nxt(m_wr);
`endif
        end
        2'b10: m_rd = p;
        default: begin
          if (was_hold && !a) begin
            m_err = 1'b1;
          end else begin
            acc    = 1'b1;
            m_hold = 1'b1;
            if (int'(m_rd) < DEPTH) m_dout = m_mem[m_rd];
            else begin
              m_dout = 8'd0;
              m_err  = 1'b1;
            end
`ifdef SPI_RAM_ADDR_AUTOINC_EN
            m_rd = nxt(m_rd);
`endif
          end
        end
      endcase
    end
    if (was_hold && a && !acc) m_hold = 1'b0;
  endtask

  // driver: called at a negedge, drives one frame, returns at the next negedge
  task automatic apply(input bit v, input logic [1:0] c, input logic [7:0] p, input bit a);
    din      = {c, p};
    rx_valid = v;
    tx_ack   = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(input bit v, input logic [1:0] c, input logic [7:0] p, input bit a,
                     input string tag);
    model_step(v, c, p, a);
    apply(v, c, p, a);
    chk({tag, " dout"}, dout, m_dout);
    chk({tag, " tx_valid"}, tx_valid, m_hold);
    chk({tag, " err"}, err, m_err);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    apply(1'b0, 2'b00, 8'h00, 1'b0);
    rst_n  = 1'b1;
    m_wr   = 8'd0;
    m_rd   = 8'd0;
    m_dout = 8'd0;
    m_hold = 1'b0;
    m_err  = 1'b0;
    chk({tag, " dout"}, dout, 0);
    chk({tag, " tx_valid"}, tx_valid, 0);
    chk({tag, " err"}, err, 0);
  endtask

  // main sequence
  initial begin
    @(negedge clk);
    @(negedge clk);
    do_reset("reset");

`ifndef SPI_RAM_ADDR_AUTOINC_EN
    tbl.push_back(mk(1, 2'b00, 8'h05, 0, 8'h00, 0, 0)); // 0 WR_ADDR 05
    tbl.push_back(mk(1, 2'b01, 8'hA5, 0, 8'h00, 0, 0)); // 1 WR_DATA A5
    tbl.push_back(mk(1, 2'b10, 8'h05, 0, 8'h00, 0, 0)); // 2 RD_ADDR 05
    tbl.push_back(mk(1, 2'b11, 8'h00, 0, 8'hA5, 1, 0)); // 3 RD_DATA -> A5
    tbl.push_back(mk(0, 2'b00, 8'h00, 0, 8'hA5, 1, 0)); // 4 held
    tbl.push_back(mk(0, 2'b00, 8'h00, 1, 8'hA5, 0, 0)); // 5 ack drops tx_valid
    tbl.push_back(mk(1, 2'b11, 8'h00, 0, 8'hA5, 1, 0)); // 6 read again
    tbl.push_back(mk(1, 2'b00, 8'h06, 0, 8'hA5, 1, 0)); // 7 writes accepted in hold
    tbl.push_back(mk(1, 2'b01, 8'h5C, 0, 8'hA5, 1, 0)); // 8
    tbl.push_back(mk(1, 2'b10, 8'h06, 0, 8'hA5, 1, 0)); // 9
    tbl.push_back(mk(1, 2'b11, 8'h00, 0, 8'hA5, 1, 1)); // 10 rejected read
    tbl.push_back(mk(0, 2'b00, 8'h00, 0, 8'hA5, 1, 0)); // 11 err one cycle
    tbl.push_back(mk(1, 2'b11, 8'h00, 1, 8'h5C, 1, 0)); // 12 back-to-back
    tbl.push_back(mk(0, 2'b00, 8'h00, 1, 8'h5C, 0, 0)); // 13 ack
    tbl.push_back(mk(0, 2'b00, 8'h00, 1, 8'h5C, 0, 0)); // 14 ack in IDLE ignored
    tbl.push_back(mk(1, 2'b00, 8'hF0, 0, 8'h5C, 0, 0)); // 15 WR_ADDR F0
    tbl.push_back(mk(1, 2'b01, 8'h33, 0, 8'h5C, 0, 1)); // 16 out-of-range write
    tbl.push_back(mk(1, 2'b10, 8'hF0, 0, 8'h5C, 0, 0)); // 17 RD_ADDR F0
    tbl.push_back(mk(1, 2'b11, 8'h00, 0, 8'h00, 1, 1)); // 18 out-of-range read
    tbl.push_back(mk(0, 2'b00, 8'h00, 1, 8'h00, 0, 0)); // 19 ack
    tbl.push_back(mk(0, 2'b00, 8'h06, 0, 8'h00, 0, 0)); // 20 rx_valid=0 frames
    tbl.push_back(mk(0, 2'b01, 8'hFF, 0, 8'h00, 0, 0)); // 21
    tbl.push_back(mk(0, 2'b10, 8'h05, 0, 8'h00, 0, 0)); // 22
    tbl.push_back(mk(0, 2'b11, 8'h00, 0, 8'h00, 0, 0)); // 23
    tbl.push_back(mk(1, 2'b11, 8'h00, 0, 8'h00, 1, 1)); // 24 rd_addr still F0
    tbl.push_back(mk(0, 2'b00, 8'h00, 1, 8'h00, 0, 0)); // 25
    tbl.push_back(mk(1, 2'b01, 8'h77, 0, 8'h00, 0, 1)); // 26 wr_addr still F0

    for (int i = 0; i < tbl.size(); i++) begin
      model_step(tbl[i].v, tbl[i].c, tbl[i].p, tbl[i].a);
      apply(tbl[i].v, tbl[i].c, tbl[i].p, tbl[i].a);
      chk($sformatf("row%0d dout", i), dout, tbl[i].exp_dout);
      chk($sformatf("row%0d tx_valid", i), tx_valid, tbl[i].exp_tv);
      chk($sformatf("row%0d err", i), err, tbl[i].exp_err);
    end
`else
    // auto-increment wrap at the last implemented word
    cyc(1, 2'b00, 8'd199, 0, "ai wr_addr");
    cyc(1, 2'b01, 8'h11, 0, "ai wr1");
    cyc(1, 2'b01, 8'h22, 0, "ai wr2");
    cyc(1, 2'b10, 8'd199, 0, "ai rd_addr");
    cyc(1, 2'b11, 8'h00, 0, "ai rd1");
    chk("ai rd1 value", dout, 8'h11);
    cyc(1, 2'b11, 8'h00, 1, "ai rd2");
    chk("ai rd2 value", dout, 8'h22);
    cyc(0, 2'b00, 8'h00, 1, "ai ack");
`endif

    // reset in TX_HOLD, memory survives
    cyc(1, 2'b00, 8'h05, 0, "rst wr_addr");
    cyc(1, 2'b01, 8'hA5, 0, "rst wr_data");
    cyc(1, 2'b10, 8'h05, 1, "rst rd_addr");
    cyc(1, 2'b11, 8'h00, 1, "rst rd");
    chk("rst hold tx_valid", tx_valid, 1);
    do_reset("rst in hold");
    cyc(1, 2'b10, 8'h05, 0, "post rst rd_addr");
    cyc(1, 2'b11, 8'h00, 0, "post rst rd");
    chk("post rst value", dout, 8'hA5);
    cyc(0, 2'b00, 8'h00, 1, "post rst ack");

    // fill every implemented word so random reads are well defined
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 2'b00, 8'(i), 0, "fill addr");
      cyc(1, 2'b01, 8'($urandom_range(0, 255)), 0, "fill data");
    end

    // random frames against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rand reset");
      end else begin
        cyc($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
